// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES round sequencer: block and key-index widths,
// the controller state encoding, and a helper that maps an AES key size in
// bits to the number of rounds it needs.
// ----------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_BLK_W = 128;
  localparam int KEY_IDX_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    MIX    = 3'd2,
    WB     = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Round count for a given key size; anything unrecognised falls back to AES-128.
  function automatic int nr_for_key(input int key_bits);
    int nr;
    case (key_bits)
      32'sd128: nr = 32'sd10;
      32'sd192: nr = 32'sd12;
      32'sd256: nr = 32'sd14;
      default:  nr = 32'sd10;
    endcase
    return nr;
  endfunction

endpackage

// File: rtl/aes_round_seq.sv
// ----------------------------------------------------------------------------
// aes_round_seq
// Controller for a two-cycle AES round datapath (shared middle-round unit plus
// a final-round unit). It accepts a plaintext, applies the initial
// AddRoundKey itself, steps NR rounds through the datapath while fetching
// round keys by index, captures the ciphertext and hands it out over a
// valid/ready handshake. One block is in flight at a time.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready/in_data  plaintext handshake (sampled only on accept)
//   out_valid/out_ready/out_data ciphertext handshake (out_data registered)
//   abort                      synchronous flush of the block in flight
//   busy                       high whenever the controller is not IDLE
//   key_idx/key_data           round-key store lookup (combinational store)
//   rnd_state_in/rnd_key       state and key presented to both round units
//   rnd_state_out              registered output of the middle-round unit
//   fin_state_out              registered output of the final-round unit
// ----------------------------------------------------------------------------
module aes_round_seq
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_data,
  input  logic                 abort,
  output logic                 busy,
  output logic [KEY_IDX_W-1:0] key_idx,
  input  logic [AES_BLK_W-1:0] key_data,
  output logic [AES_BLK_W-1:0] rnd_state_in,
  output logic [AES_BLK_W-1:0] rnd_key,
  input  logic [AES_BLK_W-1:0] rnd_state_out,
  input  logic [AES_BLK_W-1:0] fin_state_out
);

  localparam logic [KEY_IDX_W-1:0] NR_IDX   = KEY_IDX_W'(NR);
  localparam logic [KEY_IDX_W-1:0] RND_ZERO = {KEY_IDX_W{1'b0}};
  localparam logic [KEY_IDX_W-1:0] RND_ONE  = {{(KEY_IDX_W-1){1'b0}}, 1'b1};
  localparam logic [AES_BLK_W-1:0] BLK_ZERO = {AES_BLK_W{1'b0}};

  state_e               state_q, state_d;
  logic [KEY_IDX_W-1:0] rnd_q, rnd_d;
  logic [AES_BLK_W-1:0] wreg_q, wreg_d;
  logic [AES_BLK_W-1:0] out_q, out_d;
  logic                 abort_hit;

  // Controller registers; reset leaves the block idle with counter, whitening and result cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rnd_q   <= RND_ZERO;
      wreg_q  <= BLK_ZERO;
      out_q   <= BLK_ZERO;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      wreg_q  <= wreg_d;
      out_q   <= out_d;
    end
  end

  // abort only matters once a block is in flight; in IDLE a new block is still accepted.
  assign abort_hit = abort && (state_q != IDLE);

  // Next-state, round counter and capture logic; abort beats every other transition.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    wreg_d  = wreg_q;
    out_d   = out_q;
    if (abort_hit) begin
      // out_data is deliberately left untouched so the last result survives a flush.
      state_d = IDLE;
      rnd_d   = RND_ZERO;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            // Initial AddRoundKey: key_idx is 0 in IDLE, so key_data is round key 0.
            wreg_d  = in_data ^ key_data;
            rnd_d   = RND_ONE;
            state_d = LOOKUP;
          end else begin
            state_d = IDLE;
          end
        end
        LOOKUP: begin
          state_d = MIX;
        end
        MIX: begin
          if (rnd_q == NR_IDX) begin
            state_d = WB;
          end else begin
            rnd_d   = rnd_q + RND_ONE;
            state_d = LOOKUP;
          end
        end
        WB: begin
          // Final-round unit output is only meaningful right after round NR's MIX.
          out_d   = fin_state_out;
          state_d = DONE;
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
          end
        end
        default: begin
          state_d = IDLE;
          rnd_d   = RND_ZERO;
        end
      endcase
    end
  end

  // Output decode from the current state.
  always_comb begin
    in_ready     = 1'b0;
    busy         = 1'b1;
    out_valid    = 1'b0;
    key_idx      = RND_ZERO;
    rnd_state_in = BLK_ZERO;
    rnd_key      = BLK_ZERO;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      LOOKUP: begin
        key_idx = rnd_q;
        // The datapath register updates every clock, so the fed-back state
        // from the previous round is only valid in this cycle.
        if (rnd_q == RND_ONE) begin
          rnd_state_in = wreg_q;
        end else begin
          rnd_state_in = rnd_state_out;
        end
      end
      MIX: begin
        // The round units consume the key in their second cycle only; the
        // key bus is held at zero elsewhere so idle and reset outputs are quiet.
        key_idx = rnd_q;
        rnd_key = key_data;
      end
      WB: begin
        busy = 1'b1;
      end
      DONE: begin
        out_valid = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  assign out_data = out_q;

endmodule

// File: tb/tb_aes_round_seq.sv
// ----------------------------------------------------------------------------
// tb_aes_round_seq
// Directed bench for the AES round sequencer. Two instances (NR=10, NR=14)
// are each wrapped with a behavioural two-cycle round datapath and a key
// store built from a behavioural key expansion. Ciphertexts are compared with
// the FIPS-197 reference values.
// ----------------------------------------------------------------------------
module tb_aes_round_seq;
  import aes_pkg::*;

  localparam logic [127:0] PT       = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K128     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K256     = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256    = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] WHITE128 = 128'h00102030405060708090a0b0c0d0e0f0;

  logic         clk, rst_n;
  logic [127:0] in_data;

  logic         in_valid10, in_ready10, out_valid10, out_ready10, abort10, busy10;
  logic [127:0] out_data10, key_data10, rsi10, rkb10, rso10, fso10, s1_10;
  logic [3:0]   key_idx10;

  logic         in_valid14, in_ready14, out_valid14, out_ready14, abort14, busy14;
  logic [127:0] out_data14, key_data14, rsi14, rkb14, rso14, fso14, s1_14;
  logic [3:0]   key_idx14;

  logic [7:0]   sbox_t [0:255];
  logic [127:0] rk10 [0:15];
  logic [127:0] rk14 [0:15];

  int checks;
  int errors;

  aes_round_seq #(.NR(nr_for_key(128))) u10 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid10), .in_ready(in_ready10), .in_data(in_data),
    .out_valid(out_valid10), .out_ready(out_ready10), .out_data(out_data10),
    .abort(abort10), .busy(busy10),
    .key_idx(key_idx10), .key_data(key_data10),
    .rnd_state_in(rsi10), .rnd_key(rkb10),
    .rnd_state_out(rso10), .fin_state_out(fso10)
  );

  aes_round_seq #(.NR(nr_for_key(256))) u14 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid14), .in_ready(in_ready14), .in_data(in_data),
    .out_valid(out_valid14), .out_ready(out_ready14), .out_data(out_data14),
    .abort(abort14), .busy(busy14),
    .key_idx(key_idx14), .key_data(key_data14),
    .rnd_state_in(rsi14), .rnd_key(rkb14),
    .rnd_state_out(rso14), .fin_state_out(fso14)
  );

  assign key_data10 = rk10[key_idx10];
  assign key_data14 = rk14[key_idx14];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural AES helpers ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // SubBytes + ShiftRows; byte i sits at row i%4, column i/4.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = sbox_t[s[127-8*((i % 4) + 4*(((i / 4) + (i % 4)) % 4)) -: 8]];
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] round_key(input int nk, input logic [255:0] key, input int r);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 60; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Round units: state captured in cycle 1, keyed result registered at the end of cycle 2.
  always @(posedge clk) begin
    s1_10 <= rsi10;
    rso10 <= mix_cols(sub_shift(s1_10)) ^ rkb10;
    fso10 <= sub_shift(s1_10) ^ rkb10;
    s1_14 <= rsi14;
    rso14 <= mix_cols(sub_shift(s1_14)) ^ rkb14;
    fso14 <= sub_shift(s1_14) ^ rkb14;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic accept10();
    in_valid10 = 1'b1;
    in_data    = PT;
    chk("accept_in_ready", 128'(in_ready10), 128'(1'b1));
    chk("accept_key_idx", 128'(key_idx10), 128'(4'd0));
    @(negedge clk);
    in_valid10 = 1'b0;
    chk("round1_state_in", rsi10, WHITE128);
  endtask

  // Called at T1; counts cycles until out_valid (bounded) and checks the result.
  task automatic wait_out10(input string tag, input bit trace);
    int lat;
    lat = 1;
    while (out_valid10 !== 1'b1 && lat < 100) begin
      if (trace && lat <= 20) chk("key_idx_trace", 128'(key_idx10), 128'((lat + 1) / 2));
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 128'(lat), 128'(22));
    chk({tag, "_data"}, out_data10, CT128);
  endtask

  task automatic out_hs10();
    out_ready10 = 1'b1;
    @(negedge clk);
    out_ready10 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    int   lat14;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    in_data = 128'h0;
    in_valid10 = 1'b0; out_ready10 = 1'b0; abort10 = 1'b0;
    in_valid14 = 1'b0; out_ready14 = 1'b0; abort14 = 1'b0;
    for (int x = 0; x < 256; x++) sbox_t[x] = sbox_calc(8'(x));
    for (int r = 0; r < 16; r++) begin
      rk10[r] = (r <= 10) ? round_key(4, {K128, 128'h0}, r) : 128'h0;
      rk14[r] = (r <= 14) ? round_key(8, K256, r) : 128'h0;
    end

    // Reset state
    @(negedge clk);
    chk("reset_in_ready", 128'(in_ready10), 128'(1'b1));
    chk("reset_busy", 128'(busy10), 128'(1'b0));
    chk("reset_out_valid", 128'(out_valid10), 128'(1'b0));
    chk("reset_key_idx", 128'(key_idx10), 128'(4'd0));
    chk("reset_out_data", out_data10, 128'h0);
    chk("reset_state_in", rsi10, 128'h0);
    chk("reset_in_ready14", 128'(in_ready14), 128'(1'b1));
    chk("reset_busy14", 128'(busy14), 128'(1'b0));
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 AES-128 block with key_idx trace
    accept10();
    wait_out10("fips128", 1'b1);

    // Backpressure: result must hold while out_ready stays low
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 128'(out_valid10), 128'(1'b1));
      chk("bp_out_data", out_data10, CT128);
      chk("bp_in_ready", 128'(in_ready10), 128'(1'b0));
    end
    out_hs10();
    chk("hs_in_ready", 128'(in_ready10), 128'(1'b1));
    chk("hs_out_valid", 128'(out_valid10), 128'(1'b0));

    // Second block right away; in_valid kept high with junk data while busy
    accept10();
    in_valid10 = 1'b1;
    in_data    = ~PT;
    wait_out10("b2b", 1'b0);
    in_valid10 = 1'b0;
    out_hs10();

    // Abort in round 4 MIX (T8)
    accept10();
    repeat (7) @(negedge clk);
    chk("abort_pre_key_idx", 128'(key_idx10), 128'(4'd4));
    abort10 = 1'b1;
    @(negedge clk);
    abort10 = 1'b0;
    chk("abort_busy", 128'(busy10), 128'(1'b0));
    chk("abort_in_ready", 128'(in_ready10), 128'(1'b1));
    chk("abort_out_data_kept", out_data10, CT128);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid10 !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_out_valid", 128'(seen), 128'(1'b0));
    accept10();
    wait_out10("post_abort", 1'b0);
    out_hs10();

    // Reset pulse during round 6 (T11 LOOKUP)
    accept10();
    repeat (10) @(negedge clk);
    chk("rst_pre_key_idx", 128'(key_idx10), 128'(4'd6));
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 128'(in_ready10), 128'(1'b1));
    chk("rst_busy", 128'(busy10), 128'(1'b0));
    chk("rst_out_valid", 128'(out_valid10), 128'(1'b0));
    chk("rst_out_data", out_data10, 128'h0);
    chk("rst_key_idx", 128'(key_idx10), 128'(4'd0));
    chk("rst_state_in", rsi10, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // abort while IDLE with in_valid: block is accepted normally
    abort10 = 1'b1;
    accept10();
    abort10 = 1'b0;
    wait_out10("post_reset", 1'b0);

    // abort together with out handshake: back to IDLE, result retained
    out_ready10 = 1'b1;
    abort10     = 1'b1;
    @(negedge clk);
    out_ready10 = 1'b0;
    abort10     = 1'b0;
    chk("abort_hs_out_valid", 128'(out_valid10), 128'(1'b0));
    chk("abort_hs_in_ready", 128'(in_ready10), 128'(1'b1));
    chk("abort_hs_out_data", out_data10, CT128);

    // NR=14 with the FIPS-197 AES-256 key
    in_valid14 = 1'b1;
    in_data    = PT;
    chk("accept14_in_ready", 128'(in_ready14), 128'(1'b1));
    @(negedge clk);
    in_valid14 = 1'b0;
    lat14 = 1;
    while (out_valid14 !== 1'b1 && lat14 < 100) begin
      @(negedge clk);
      lat14++;
    end
    chk("fips256_latency", 128'(lat14), 128'(30));
    chk("fips256_data", out_data14, CT256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_round_seq.md
Name: aes_round_seq

Overview:
- Sequencer for the two-cycle AES round datapath. The datapath comprises a shared middle-round unit and a final-round unit; both take state_in in cycle 1 and the key in cycle 2, and both register state_out at the end of cycle 2 with no enable.
- Accepts a plaintext block and performs the initial AddRoundKey itself.
- Drives NR rounds through the datapath, fetching round keys by index from an external round-key store.
- Captures the ciphertext and returns it over a valid/ready handshake. One block is in flight at a time.

Parameters:
- NR, 10, total number of rounds; legal values are 10, 12 and 14.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  plaintext offered.
- in_ready  out  1  controller can accept a plaintext.
- in_data  in  128  plaintext block.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  consumer takes the ciphertext.
- out_data  out  128  ciphertext block.
- abort  in  1  synchronous flush of the block in flight.
- busy  out  1  high in every state except IDLE.
- key_idx  out  4  round-key index to the key store.
- key_data  in  128  round key; combinational from key_idx, valid in the same cycle.
- rnd_state_in  out  128  state_in to both round units.
- rnd_key  out  128  key to both round units; equals key_data.
- rnd_state_out  in  128  state_out of the middle-round unit.
- fin_state_out  in  128  state_out of the final-round unit.

Behaviour:
- FSM states: IDLE, LOOKUP, MIX, WB, DONE. Round counter rnd is 4 bits. The whitening register wreg is 128 bits.
- Reset (async, rst_n=0) puts the block in IDLE with rnd=0, wreg=0 and out_data=0. All outputs are 0 except in_ready=1.
- IDLE:
  - in_ready=1, key_idx=0.
  - On in_valid: wreg<=in_data^key_data, rnd<=1, go to LOOKUP.
- LOOKUP:
  - key_idx=rnd.
  - rnd_state_in = wreg when rnd==1, otherwise rnd_state_out. The fed-back rnd_state_out is valid only in this cycle, because the datapath output register updates every clock.
  - Next state: MIX.
- MIX:
  - key_idx=rnd; rnd_key carries round key rnd.
  - If rnd==NR go to WB; otherwise rnd<=rnd+1 and go to LOOKUP.
- WB:
  - out_data<=fin_state_out, go to DONE.
- DONE:
  - out_valid=1; out_data stays stable.
  - On out_ready go to IDLE.
- rnd_state_in is 0 outside LOOKUP. In IDLE, key_idx must be 0 so that key_data presents key 0.
- Latency: acceptance in cycle T0; round r occupies LOOKUP at T(2r-1) and MIX at T(2r); WB at T(2NR+1); out_valid first high at T(2NR+2). For NR=10 this is T22.
- The middle-round unit is used for rounds 1..NR-1. The final-round output is consumed only after round NR.
- in_ready is low in all states other than IDLE; in_valid is ignored there. in_data is sampled only on acceptance.
- Back-to-back operation: the DONE→IDLE handshake costs one cycle, so the next acceptance can happen at the earliest one cycle after the out handshake.
- out_valid stays high until out_ready, regardless of how long that takes; out_data holds until the next WB.
- abort:
  - In any state other than IDLE it forces IDLE at the next edge. out_valid drops; out_data is retained.
  - abort has priority over all other transitions, including a simultaneous out handshake (the result counts as consumed).
  - abort in IDLE with in_valid high: the block is accepted normally.
- Reset mid-operation: immediate return to IDLE; no output is produced.
- rnd never exceeds NR.

Decomposition:
- Shared package aes_pkg:
  - state enum {IDLE, LOOKUP, MIX, WB, DONE};
  - AES_BLK_W=128 and KEY_IDX_W=4;
  - a round-count function mapping key size to NR.
- No sub-module; the FSM and the datapath muxes are a single module of roughly 150-200 lines.

Test Plan:
- Key schedule is modelled by the bench. FIPS-197 vector: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff, NR=10 → out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid first high exactly 22 cycles after acceptance.
- key_idx trace for the same run: 0 in the accept cycle, then 1,1,2,2,…,10,10 across LOOKUP/MIX.
- Backpressure: out_ready held low for 5 cycles → out_valid and out_data stable, in_ready low; out_ready high → IDLE the next cycle, second block accepted the cycle after.
- abort asserted in round 4 MIX → busy low the next cycle, out_valid never rises; a fresh FIPS block then completes with the correct result.
- rst_n pulsed low during round 6 → all outputs 0 immediately, in_ready=1; a subsequent block produces the correct ciphertext.
- NR=14 with FIPS-197 AES-256 key 000102…1e1f, same plaintext → 8ea2b7ca516745bfeafc49904b496089 at T30.
